// File: rtl/modexp_pkg.sv
// Shared constants for the modexp_ctrl square-and-multiply controller.
package modexp_pkg;

  localparam int unsigned DefWidth   = 256;
  localparam int unsigned DefKw      = 9;
  localparam int unsigned DefTimeout = 1024;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StCheck   = 3'd1;
  localparam logic [2:0] StMulReq  = 3'd2;
  localparam logic [2:0] StMulWait = 3'd3;
  localparam logic [2:0] StSqrReq  = 3'd4;
  localparam logic [2:0] StSqrWait = 3'd5;
  localparam logic [2:0] StDone    = 3'd6;

endpackage

// File: rtl/modexp_ctrl.sv
// Square-and-multiply modular exponentiation controller driving an external ModuloProduct unit.
// Optional response watchdog enabled with `define MODEXP_TIMEOUT_EN.
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned KW      = DefKw,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_base,
  input  logic [WIDTH-1:0] i_exp,
  input  logic [WIDTH-1:0] i_N,
  input  logic [KW-1:0]    i_k,
  output logic [WIDTH-1:0] o_result,
  output logic             o_done,
  output logic             o_busy,
  output logic             o_error,
  output logic             mp_valid,
  output logic [WIDTH-1:0] mp_N,
  output logic [WIDTH-1:0] mp_a,
  output logic [WIDTH-1:0] mp_b,
  output logic [KW-1:0]    mp_k,
  input  logic [WIDTH-1:0] mp_result,
  input  logic             mp_ready
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("modexp_ctrl: TIMEOUT must be at least 2");
  end

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] t_q, t_d, e_q, e_d, r_q, r_d, n_q, n_d, res_q, res_d;
  logic [KW-1:0]    k_q, k_d;
  logic             err_q, err_d;
  logic             waiting, requesting, timeout;

  assign requesting = (state_q == StMulReq) || (state_q == StSqrReq);
  assign waiting    = (state_q == StMulWait) || (state_q == StSqrWait);

`ifdef MODEXP_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q, cnt_d;

  // The request cycle counts as the first cycle of the wait budget.
  always_comb begin
    cnt_d = cnt_q;
    if (requesting) begin
      cnt_d = CntW'(1);
    end else if (waiting && !mp_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign timeout = waiting && !mp_ready && (cnt_q == CntW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    e_d     = e_q;
    r_d     = r_q;
    n_d     = n_q;
    k_d     = k_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (i_start) begin
          state_d = StCheck;
          t_d     = i_base;
          e_d     = i_exp;
          n_d     = i_N;
          k_d     = i_k;
          r_d     = {{(WIDTH-1){1'b0}}, 1'b1};
          err_d   = 1'b0;
        end
      end
      StCheck: begin
        if (e_q == '0) begin
          state_d = StDone;
          res_d   = r_q;
        end else if (e_q[0]) begin
          state_d = StMulReq;
        end else begin
          state_d = StSqrReq;
        end
      end
      StMulReq: state_d = StMulWait;
      StMulWait: begin
        if (mp_ready) begin
          r_d = mp_result;
          // No exponent bits left above this one: skip the final squaring.
          if ((e_q >> 1) == '0) begin
            state_d = StDone;
            res_d   = mp_result;
          end else begin
            state_d = StSqrReq;
          end
        end else if (timeout) begin
          state_d = StDone;
          res_d   = '0;
          err_d   = 1'b1;
        end
      end
      StSqrReq: state_d = StSqrWait;
      StSqrWait: begin
        if (mp_ready) begin
          t_d     = mp_result;
          e_d     = e_q >> 1;
          state_d = StCheck;
        end else if (timeout) begin
          state_d = StDone;
          res_d   = '0;
          err_d   = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      t_q     <= '0;
      e_q     <= '0;
      r_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      e_q     <= e_d;
      r_q     <= r_d;
      n_q     <= n_d;
      k_q     <= k_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Operands come straight from r/t, which only change when the product is consumed.
  always_comb begin
    mp_a = '0;
    mp_b = '0;
    if ((state_q == StMulReq) || (state_q == StMulWait)) begin
      mp_a = r_q;
      mp_b = t_q;
    end else if (requesting || waiting) begin
      mp_a = t_q;
      mp_b = t_q;
    end
  end

  assign mp_valid = requesting;
  assign mp_N     = n_q;
  assign mp_k     = k_q;
  assign o_result = res_q;
  assign o_done   = (state_q == StDone);
  assign o_busy   = (state_q != StIdle);
  assign o_error  = err_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Self-checking bench for modexp_ctrl with a behavioural ModuloProduct responder.
module tb_modexp_ctrl;

  localparam int unsigned W  = 32;
  localparam int unsigned KW = 9;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  base = '0, ex = '0, n = '0;
  logic [KW-1:0] k = '0;
  logic [W-1:0]  result, mp_N, mp_a, mp_b;
  logic          done, busy, error, mp_valid, mp_ready;
  logic [KW-1:0] mp_k;
  logic [W-1:0]  mp_result = '0;

  logic          resp_ready = 1'b0, spur_ready = 1'b0, stale = 1'b0;
  bit            resp_en = 1'b1;
  int            lat = 1, cnt = 0, unstable = 0;
  logic [W-1:0]  pend = '0, cap_a = '0, cap_b = '0;
  logic [W-1:0]  log_a[$], log_b[$], exp_a[$], exp_b[$];

  int total = 0;
  int bad = 0;

  assign mp_ready = resp_ready | spur_ready;

  always #5 clk = ~clk;

  modexp_ctrl #(.WIDTH(W), .KW(KW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base(base), .i_exp(ex), .i_N(n), .i_k(k),
    .o_result(result), .o_done(done), .o_busy(busy), .o_error(error),
    .mp_valid(mp_valid), .mp_N(mp_N), .mp_a(mp_a), .mp_b(mp_b), .mp_k(mp_k),
    .mp_result(mp_result), .mp_ready(mp_ready)
  );

  function automatic logic [W-1:0] mm(input logic [W-1:0] a, b, m);
    logic [2*W-1:0] p;
    p = (2*W)'(a) * (2*W)'(b);
    return W'(p % (2*W)'(m));
  endfunction

  // Responder: answers each request lat+1 cycles after the request cycle.
  always @(posedge clk) begin
    resp_ready <= 1'b0;
    if (rst) stale <= 1'b1;
    if (mp_valid) begin
      pend  <= mm(mp_a, mp_b, mp_N);
      cap_a <= mp_a;
      cap_b <= mp_b;
      cnt   <= lat;
      stale <= 1'b0;
      log_a.push_back(mp_a);
      log_b.push_back(mp_b);
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1 && resp_en) begin
        resp_ready <= 1'b1;
        mp_result  <= pend;
        if (!stale && (mp_a !== cap_a || mp_b !== cap_b)) unstable <= unstable + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference: scan exponent bits LSB first, multiply on set bits, square while bits remain.
  task automatic model(input logic [W-1:0] b, e, m, output logic [W-1:0] res);
    logic [W-1:0] r, t, ee;
    exp_a.delete();
    exp_b.delete();
    r  = 1;
    t  = b;
    ee = e;
    while (ee != 0) begin
      if (ee[0]) begin
        exp_a.push_back(r);
        exp_b.push_back(t);
        r = mm(r, t, m);
      end
      ee = ee >> 1;
      if (ee != 0) begin
        exp_a.push_back(t);
        exp_b.push_back(t);
        t = mm(t, t, m);
      end
    end
    res = r;
  endtask

  task automatic check_seq(input string name);
    int nmin;
    check({name, "_nreq"}, 64'(log_a.size()), 64'(exp_a.size()));
    nmin = (log_a.size() < exp_a.size()) ? log_a.size() : exp_a.size();
    for (int i = 0; i < nmin; i++) begin
      check({name, "_req_a"}, 64'(log_a[i]), 64'(exp_a[i]));
      check({name, "_req_b"}, 64'(log_b[i]), 64'(exp_b[i]));
    end
  endtask

  task automatic run_op(input logic [W-1:0] b, e, m, input logic [KW-1:0] kk, input int l,
                        input bit disturb, output logic [W-1:0] res, output logic err,
                        output int done_cyc, output int req_cyc);
    lat = l;
    log_a.delete();
    log_b.delete();
    base = b; ex = e; n = m; k = kk; start = 1'b1;
    req_cyc = -1;
    done_cyc = -1;
    res = '0;
    err = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 4000 && done_cyc < 0; c++) begin
      if (mp_valid && req_cyc < 0) req_cyc = c;
      if (done) begin
        done_cyc = c;
        res = result;
        err = error;
        check("busy_in_done", 64'(busy), 64'(1));
        check("mp_N_held", 64'(mp_N), 64'(m));
        check("mp_k_held", 64'(mp_k), 64'(kk));
      end else begin
        start      = disturb && (c == 1 || c == 3);
        spur_ready = disturb && (c == 1);
        base       = disturb ? (b ^ 1) : b;
        @(negedge clk);
      end
    end
    start = 1'b0;
    spur_ready = 1'b0;
    base = b;
    if (done_cyc < 0) check("done_within_bound", 64'(0), 64'(1));
    @(negedge clk);
    check("done_single_pulse", 64'(done), 64'(0));
    check("busy_after_done", 64'(busy), 64'(0));
  endtask

  typedef struct {
    logic [W-1:0]  b, e, m;
    logic [KW-1:0] k;
    int            lat;
    logic [W-1:0]  res;
    int            nreq;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [W-1:0] res, mres, rb, re, rm;
    logic         err;
    int           dc, rc, c;

    vecs[0] = '{b: 1000, e: 2,  m: 18795, k: 14, lat: 10, res: 3865, nreq: 2};
    vecs[1] = '{b: 3,    e: 5,  m: 7,     k: 3,  lat: 2,  res: 5,    nreq: 4};
    vecs[2] = '{b: 1234, e: 0,  m: 18795, k: 14, lat: 1,  res: 1,    nreq: 0};
    vecs[3] = '{b: 2,    e: 10, m: 1000,  k: 10, lat: 3,  res: 24,   nreq: 5};
    vecs[4] = '{b: 5,    e: 1,  m: 13,    k: 4,  lat: 1,  res: 5,    nreq: 1};
    vecs[5] = '{b: 12,   e: 3,  m: 13,    k: 4,  lat: 4,  res: 12,   nreq: 3};

    repeat (3) @(negedge clk);
    check("rst_result", 64'(result), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_error", 64'(error), 64'(0));
    check("rst_valid", 64'(mp_valid), 64'(0));
    check("rst_mp_N", 64'(mp_N), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].b, vecs[i].e, vecs[i].m, vecs[i].k, vecs[i].lat, 1'b0, res, err, dc, rc);
      check("vec_result", 64'(res), 64'(vecs[i].res));
      check("vec_nreq", 64'(log_a.size()), 64'(vecs[i].nreq));
      check("vec_error", 64'(err), 64'(0));
      model(vecs[i].b, vecs[i].e, vecs[i].m, mres);
      check_seq("vec");
      if (vecs[i].e == 0) check("exp0_done_latency", 64'(dc), 64'(2));
      if (i == 0 && log_a.size() == 2) begin
        check("plan_sqr_a", 64'(log_a[0]), 64'(1000));
        check("plan_sqr_b", 64'(log_b[0]), 64'(1000));
        check("plan_mul_a", 64'(log_a[1]), 64'(1));
        check("plan_mul_b", 64'(log_b[1]), 64'(3865));
      end
    end

    // Spurious start and mp_ready while in CHECK must be ignored.
    run_op(3, 5, 7, 3, 2, 1'b1, res, err, dc, rc);
    check("disturb_result", 64'(res), 64'(5));
    model(3, 5, 7, mres);
    check_seq("disturb");

    // Reset while waiting on the squaring product.
    lat = 5;
    log_a.delete();
    log_b.delete();
    base = 3; ex = 5; n = 7; k = 3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (log_a.size() < 2 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("rst_mid_reach_sqr", 64'(log_a.size()), 64'(2));
    check("rst_mid_busy_before", 64'(busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_valid", 64'(mp_valid), 64'(0));
    check("rst_mid_result", 64'(result), 64'(0));
    c = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || done || mp_valid) c++;
    end
    check("late_ready_ignored", 64'(c), 64'(0));
    run_op(3, 5, 7, 3, 2, 1'b0, res, err, dc, rc);
    check("after_rst_result", 64'(res), 64'(5));

    // Randomised operations against the reference model.
    for (int i = 0; i < 20; i++) begin
      rm = W'($urandom());
      if (i % 4 == 0) rm = W'($urandom_range(2, 300));
      if (rm < 2) rm = 2;
      rb = W'($urandom()) % rm;
      re = (i % 3 == 0) ? W'($urandom_range(0, 20)) : W'($urandom());
      run_op(rb, re, rm, KW'($urandom()), $urandom_range(1, 4), 1'b0, res, err, dc, rc);
      model(rb, re, rm, mres);
      check("rand_result", 64'(res), 64'(mres));
      check_seq("rand");
    end

`ifdef MODEXP_TIMEOUT_EN
    resp_en = 1'b0;
    run_op(3, 5, 7, 3, 2, 1'b0, res, err, dc, rc);
    check("to_latency", 64'(dc - rc), 64'(TO));
    check("to_error", 64'(err), 64'(1));
    check("to_result", 64'(res), 64'(0));
    resp_en = 1'b1;
    repeat (8) @(negedge clk);
    run_op(3, 5, 7, 3, 2, 1'b0, res, err, dc, rc);
    check("to_recover_result", 64'(res), 64'(5));
    check("to_recover_error", 64'(err), 64'(0));
`endif

    check("operands_stable", 64'(unstable), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
